// File: rtl/icache_refill.sv
// Line-refill engine for the icache: fetches one 4-beat line per accepted miss,
// streams each beat into the victim way's data SRAM, then writes the tag.
module icache_refill #(
  parameter int WAY_CNT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  // miss request from fetch
  input  logic               miss_valid_i,
  output logic               miss_ready_o,
  input  logic [31:0]        miss_paddr_i,
  input  logic [WAY_CNT-1:0] miss_way_i,
  // memory bus
  output logic               bus_req_valid_o,
  input  logic               bus_req_ready_i,
  output logic [31:0]        bus_req_addr_o,
  input  logic               bus_rvalid_i,
  input  logic [31:0]        bus_rdata_i,
  input  logic               bus_rlast_i,
  // per-way SRAM write port
  output logic [WAY_CNT-1:0] data_we_o,
  output logic [WAY_CNT-1:0] tag_we_o,
  output logic [9:0]         sram_addr_o,
  output logic [31:0]        sram_data_o,
  output logic [21:0]        sram_tag_o,
  // critical word forward and status
  output logic               crit_valid_o,
  output logic [31:0]        crit_data_o,
  output logic               refill_busy_o,
  output logic               refill_done_o,
  output logic               protocol_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_TAG
  } state_t;

  state_t               state_q;
  logic [31:2]          paddr_q;
  logic [WAY_CNT-1:0]   way_q;
  logic [1:0]           cnt_q;
  logic                 err_q;

  // Byte offset within a word never affects the refill.
  logic unused_paddr_bits;
  assign unused_paddr_bits = ^miss_paddr_i[1:0];

  logic last_beat;
  assign last_beat = (cnt_q == 2'd3);

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; reset is synchronous, sampled only at clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      paddr_q <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (miss_valid_i) begin
            paddr_q <= miss_paddr_i[31:2];
            way_q   <= miss_way_i;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_req_ready_i) state_q <= S_RECV;
        end
        S_RECV: begin
          if (bus_rvalid_i) begin
            cnt_q <= cnt_q + 2'd1;
            // The beat count ends the burst; rlast is only cross-checked.
            if (bus_rlast_i != last_beat) err_q <= 1'b1;
            if (last_beat) state_q <= S_TAG;
          end
        end
        S_TAG: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    miss_ready_o    = 1'b0;
    bus_req_valid_o = 1'b0;
    bus_req_addr_o  = '0;
    data_we_o       = '0;
    tag_we_o        = '0;
    sram_addr_o     = '0;
    sram_data_o     = '0;
    sram_tag_o      = '0;
    crit_valid_o    = 1'b0;
    crit_data_o     = '0;
    refill_busy_o   = 1'b0;
    refill_done_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        miss_ready_o = 1'b1;
      end
      S_REQ: begin
        refill_busy_o   = 1'b1;
        bus_req_valid_o = 1'b1;
        bus_req_addr_o  = {paddr_q[31:4], 4'b0000};
      end
      S_RECV: begin
        refill_busy_o = 1'b1;
        if (bus_rvalid_i) begin
          data_we_o   = way_q;
          sram_addr_o = {paddr_q[11:4], cnt_q};
          sram_data_o = bus_rdata_i;
          // Beats arrive in order, so the missed word shows up exactly once.
          if (cnt_q == paddr_q[3:2]) begin
            crit_valid_o = 1'b1;
            crit_data_o  = bus_rdata_i;
          end
        end
      end
      S_TAG: begin
        refill_busy_o = 1'b1;
        refill_done_o = 1'b1;
        tag_we_o      = way_q;
        sram_addr_o   = {paddr_q[11:4], 2'b00};
        sram_tag_o    = {1'b1, 1'b0, paddr_q[31:12]};
      end
      default: ;
    endcase
  end

  assign protocol_err_o = err_q;

  // Data and tag share one SRAM address bus, so they must never overlap.
  a_we_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !((|data_we_o) && (|tag_we_o)));

  a_way_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    (miss_valid_i && miss_ready_o) |-> $onehot(miss_way_i));

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios plus randomized
// refills, each checked cycle by cycle against a transaction-level model.
module tb_icache_refill;
  localparam int WAY_CNT = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               miss_valid_i;
  logic               miss_ready_o;
  logic [31:0]        miss_paddr_i;
  logic [WAY_CNT-1:0] miss_way_i;
  logic               bus_req_valid_o;
  logic               bus_req_ready_i;
  logic [31:0]        bus_req_addr_o;
  logic               bus_rvalid_i;
  logic [31:0]        bus_rdata_i;
  logic               bus_rlast_i;
  logic [WAY_CNT-1:0] data_we_o;
  logic [WAY_CNT-1:0] tag_we_o;
  logic [9:0]         sram_addr_o;
  logic [31:0]        sram_data_o;
  logic [21:0]        sram_tag_o;
  logic               crit_valid_o;
  logic [31:0]        crit_data_o;
  logic               refill_busy_o;
  logic               refill_done_o;
  logic               protocol_err_o;

  icache_refill #(.WAY_CNT(WAY_CNT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_valid_i    (miss_valid_i),
    .miss_ready_o    (miss_ready_o),
    .miss_paddr_i    (miss_paddr_i),
    .miss_way_i      (miss_way_i),
    .bus_req_valid_o (bus_req_valid_o),
    .bus_req_ready_i (bus_req_ready_i),
    .bus_req_addr_o  (bus_req_addr_o),
    .bus_rvalid_i    (bus_rvalid_i),
    .bus_rdata_i     (bus_rdata_i),
    .bus_rlast_i     (bus_rlast_i),
    .data_we_o       (data_we_o),
    .tag_we_o        (tag_we_o),
    .sram_addr_o     (sram_addr_o),
    .sram_data_o     (sram_data_o),
    .sram_tag_o      (sram_tag_o),
    .crit_valid_o    (crit_valid_o),
    .crit_data_o     (crit_data_o),
    .refill_busy_o   (refill_busy_o),
    .refill_done_o   (refill_done_o),
    .protocol_err_o  (protocol_err_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic err_exp = 1'b0;   // sticky burst-length error the bus has provoked so far

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Outputs that must be idle whenever nothing is being written.
  task automatic check_no_write(input string ctx);
    check({ctx, ".data_we"},   data_we_o,     0);
    check({ctx, ".tag_we"},    tag_we_o,      0);
    check({ctx, ".sram_addr"}, sram_addr_o,   0);
    check({ctx, ".sram_data"}, sram_data_o,   0);
    check({ctx, ".sram_tag"},  sram_tag_o,    0);
    check({ctx, ".crit"},      crit_valid_o,  0);
    check({ctx, ".done"},      refill_done_o, 0);
  endtask

  task automatic quiet_inputs();
    miss_valid_i    = 1'b0;
    miss_paddr_i    = '0;
    miss_way_i      = '0;
    bus_req_ready_i = 1'b0;
    bus_rvalid_i    = 1'b0;
    bus_rdata_i     = '0;
    bus_rlast_i     = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    quiet_inputs();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    err_exp = 1'b0;
    #1;
    check("rst.miss_ready", miss_ready_o,    1);
    check("rst.busy",       refill_busy_o,   0);
    check("rst.req_valid",  bus_req_valid_o, 0);
    check("rst.req_addr",   bus_req_addr_o,  0);
    check("rst.err",        protocol_err_o,  0);
    check_no_write("rst");
  endtask

  // Idle cycles, optionally with stray beats that must be ignored.
  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      quiet_inputs();
      bus_rvalid_i = stray;
      bus_rdata_i  = $urandom;
      bus_rlast_i  = 1'($urandom_range(0, 1));
      #1;
      check("idle.miss_ready", miss_ready_o,    1);
      check("idle.busy",       refill_busy_o,   0);
      check("idle.req_valid",  bus_req_valid_o, 0);
      check("idle.err",        protocol_err_o,  err_exp);
      check_no_write("idle");
    end
  endtask

  // One refill transaction. gap<0 picks a random 0..2 stall before each beat;
  // bad_beat inverts rlast on that beat; abort_after<4 resets after that many beats;
  // data_seq>=0 makes beat b carry data_seq+b.
  task automatic do_refill(input logic [31:0] paddr, input logic [WAY_CNT-1:0] way,
                           input int req_delay, input int gap, input bit hold_miss,
                           input bit idle_beat, input int bad_beat, input int abort_after,
                           input int data_seq);
    logic [31:0] beat_data;
    logic [9:0]  line_addr;
    int          crit_idx;
    int          g;
    line_addr = {paddr[11:4], 2'b00};
    crit_idx  = int'(paddr[3:2]);

    // Accept cycle: the engine must be idle and ignore any beat shown now.
    @(negedge clk);
    miss_valid_i    = 1'b1;
    miss_paddr_i    = paddr;
    miss_way_i      = way;
    bus_req_ready_i = 1'b0;
    bus_rvalid_i    = idle_beat;
    bus_rdata_i     = $urandom;
    bus_rlast_i     = 1'b1;
    #1;
    check("acc.miss_ready", miss_ready_o,    1);
    check("acc.busy",       refill_busy_o,   0);
    check("acc.req_valid",  bus_req_valid_o, 0);
    check("acc.err",        protocol_err_o,  err_exp);
    check_no_write("acc");

    // Request phase: held stable until the bus takes it.
    for (int r = 0; r <= req_delay; r++) begin
      @(negedge clk);
      miss_valid_i    = hold_miss;
      miss_paddr_i    = $urandom;
      bus_req_ready_i = (r == req_delay);
      bus_rvalid_i    = 1'b0;
      bus_rlast_i     = 1'b0;
      #1;
      check("req.valid",      bus_req_valid_o, 1);
      check("req.addr",       bus_req_addr_o,  {paddr[31:4], 4'h0});
      check("req.miss_ready", miss_ready_o,    0);
      check("req.busy",       refill_busy_o,   1);
      check("req.err",        protocol_err_o,  err_exp);
      check_no_write("req");
    end

    for (int b = 0; b < 4; b++) begin
      if (b == abort_after) begin
        @(negedge clk);
        rst_n = 1'b0;
        quiet_inputs();
        @(negedge clk);
        rst_n   = 1'b1;
        err_exp = 1'b0;
        #1;
        check("abort.miss_ready", miss_ready_o,   1);
        check("abort.busy",       refill_busy_o,  0);
        check("abort.err",        protocol_err_o, 0);
        check_no_write("abort");
        idle_cycles(3, 1'b1);
        return;
      end
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        miss_valid_i    = hold_miss;
        bus_req_ready_i = 1'($urandom_range(0, 1));
        bus_rvalid_i    = 1'b0;
        bus_rlast_i     = 1'($urandom_range(0, 1));
        #1;
        check("gap.req_valid",  bus_req_valid_o, 0);
        check("gap.busy",       refill_busy_o,   1);
        check("gap.miss_ready", miss_ready_o,    0);
        check("gap.err",        protocol_err_o,  err_exp);
        check_no_write("gap");
      end
      beat_data = (data_seq >= 0) ? 32'(data_seq + b) : $urandom;
      @(negedge clk);
      miss_valid_i    = hold_miss;
      bus_req_ready_i = 1'b0;
      bus_rvalid_i    = 1'b1;
      bus_rdata_i     = beat_data;
      bus_rlast_i     = (b == 3) != (b == bad_beat);
      #1;
      check("beat.data_we",    data_we_o,       way);
      check("beat.tag_we",     tag_we_o,        0);
      check("beat.sram_addr",  sram_addr_o,     line_addr + 10'(b));
      check("beat.sram_data",  sram_data_o,     beat_data);
      check("beat.crit",       crit_valid_o,    (b == crit_idx));
      if (b == crit_idx) check("beat.crit_data", crit_data_o, beat_data);
      check("beat.done",       refill_done_o,   0);
      check("beat.req_valid",  bus_req_valid_o, 0);
      check("beat.miss_ready", miss_ready_o,    0);
      check("beat.err",        protocol_err_o,  err_exp);
      if (b == bad_beat) err_exp = 1'b1;
    end

    // Tag cycle; a stray beat here must not produce a data write.
    @(negedge clk);
    miss_valid_i = hold_miss;
    bus_rvalid_i = 1'($urandom_range(0, 1));
    bus_rdata_i  = $urandom;
    bus_rlast_i  = 1'b0;
    #1;
    check("tag.tag_we",     tag_we_o,       way);
    check("tag.data_we",    data_we_o,      0);
    check("tag.sram_addr",  sram_addr_o,    line_addr);
    check("tag.sram_tag",   sram_tag_o,     {2'b10, paddr[31:12]});
    check("tag.sram_data",  sram_data_o,    0);
    check("tag.done",       refill_done_o,  1);
    check("tag.crit",       crit_valid_o,   0);
    check("tag.busy",       refill_busy_o,  1);
    check("tag.miss_ready", miss_ready_o,   0);
    check("tag.err",        protocol_err_o, err_exp);
  endtask

  initial begin
    logic [31:0]        paddr;
    logic [WAY_CNT-1:0] way;
    rst_n = 1'b0;
    quiet_inputs();
    apply_reset();

    // Back-to-back refill with fixed data and the documented latency.
    do_refill(32'h1C00_0128, 2'b10, 0, 0, 1'b0, 1'b0, -1, 4, 'hA0);
    idle_cycles(1, 1'b0);

    // Stalled request and one idle cycle between beats.
    do_refill(32'h0000_3F44, 2'b01, 3, 1, 1'b0, 1'b0, -1, 4, -1);
    idle_cycles(1, 1'b0);

    // rlast early on beat 1: error sticks across the next refill.
    do_refill(32'h8765_4000, 2'b01, 0, 0, 1'b0, 1'b0, 1, 4, -1);
    do_refill(32'h8765_4010, 2'b10, 1, 0, 1'b0, 1'b0, -1, 4, -1);
    apply_reset();

    // rlast missing on beat 3.
    do_refill(32'h2222_2224, 2'b10, 0, 0, 1'b0, 1'b0, 3, 4, -1);
    apply_reset();

    // Reset after two beats, then stray beats.
    do_refill(32'h4000_0A08, 2'b01, 0, 0, 1'b0, 1'b0, -1, 2, -1);

    // Miss held high while busy, IDLE beat pulse; next miss accepted at once.
    do_refill(32'h5555_0030, 2'b01, 1, 0, 1'b1, 1'b1, -1, 4, -1);
    do_refill(32'h5555_004C, 2'b10, 0, 0, 1'b1, 1'b1, -1, 4, -1);
    idle_cycles(2, 1'b1);

    // Critical word at offsets 0 and 3.
    do_refill(32'h0ABC_D000, 2'b01, 0, 0, 1'b0, 1'b0, -1, 4, -1);
    do_refill(32'h0ABC_D01C, 2'b10, 0, 1, 1'b0, 1'b0, -1, 4, -1);

    // Randomized refills.
    for (int n = 0; n < 40; n++) begin
      paddr = $urandom;
      way   = WAY_CNT'(1) << $urandom_range(0, WAY_CNT - 1);
      do_refill(paddr, way, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1,
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 4, -1);
      idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Line-refill engine that sits directly upstream of the per-way icache datapath (single-port data/tag SRAMs).
- On an accepted miss, issues one 4-beat line read on the memory bus.
- Writes each returned word into the selected way's data SRAM as it arrives, then writes the tag.
- Forwards the critical (missed) word to the fetch stage when it arrives.
- While busy, the refill engine owns the way's SRAM address/write ports. The fetch-stage mux uses `refill_busy_o` to select them.

Parameters:
- `WAY_CNT`, default 2, number of cache ways; `miss_way_i`, `data_we_o` and `tag_we_o` are one-hot of this width.

Ports:
- `clk` in 1: clock
- `rst_n` in 1: synchronous, active-low reset
- `miss_valid_i` in 1: miss request valid
- `miss_ready_o` out 1: engine can accept a miss (high only in IDLE)
- `miss_paddr_i` in 32: physical address of missing fetch
- `miss_way_i` in WAY_CNT: one-hot victim way
- `bus_req_valid_o` out 1: line read request valid
- `bus_req_ready_i` in 1: bus accepts request
- `bus_req_addr_o` out 32: line-aligned address, {paddr[31:4], 4'b0}
- `bus_rvalid_i` in 1: read beat valid (engine is always ready)
- `bus_rdata_i` in 32: read beat data
- `bus_rlast_i` in 1: last beat marker
- `data_we_o` out WAY_CNT: per-way data SRAM write enable
- `tag_we_o` out WAY_CNT: per-way tag SRAM write enable
- `sram_addr_o` out 10: SRAM address, bits [11:2] of the byte address
- `sram_data_o` out 32: data SRAM write data
- `sram_tag_o` out 22: tag write data, {1'b1 valid, 1'b0 reserved, paddr[31:12]}
- `crit_valid_o` out 1: critical word available this cycle
- `crit_data_o` out 32: critical word
- `refill_busy_o` out 1: engine owns the SRAM ports (state != IDLE)
- `refill_done_o` out 1: one-cycle pulse, line and tag written
- `protocol_err_o` out 1: sticky bus burst-length error

Behaviour:
- States: IDLE, REQ, RECV, TAG.
- Reset: rst_n low at any clock edge forces IDLE and clears the beat counter, latched address/way and `protocol_err_o`. All outputs are 0 except `miss_ready_o`=1.
- Reset mid-refill abandons the line. Partially written words stay in the SRAM, but the tag is never written, so the line stays invalid. Stray beats arriving after reset are ignored.
- IDLE:
  - `miss_ready_o`=1.
  - `miss_valid_i` & `miss_ready_o` latches paddr and way, clears the beat counter, and moves to REQ next cycle.
  - `bus_rvalid_i` is ignored in IDLE.
- REQ:
  - `bus_req_valid_o`=1 and `bus_req_addr_o`={paddr[31:4],4'b0}, both held stable until `bus_req_ready_i`.
  - The handshake cycle moves the engine to RECV.
  - `bus_req_valid_o` drops the cycle after the handshake.
- RECV, each cycle with `bus_rvalid_i`=1:
  - `data_we_o` = latched way (combinational, same cycle).
  - `sram_addr_o` = {paddr[11:4], cnt}.
  - `sram_data_o` = `bus_rdata_i`.
  - cnt (2-bit) increments.
- Beat order is sequential from word 0. No wrap/critical-first ordering.
- Critical word: when cnt == paddr[3:2] on a valid beat, `crit_valid_o`=1 and `crit_data_o`=`bus_rdata_i` in the same cycle (zero latency). This happens exactly once per refill.
- RECV with `bus_rvalid_i`=0: all write enables are 0 and the state is held. There is no timeout.
- The beat count is authoritative. The valid beat with cnt==3 moves the engine to TAG regardless of `bus_rlast_i`.
- `protocol_err_o` is set (sticky until reset) if:
  - `bus_rlast_i`=1 on a beat with cnt!=3, or
  - `bus_rlast_i`=0 on the beat with cnt==3.
- TAG (exactly one cycle):
  - `tag_we_o` = latched way.
  - `sram_addr_o` = {paddr[11:4], 2'b00}.
  - `sram_tag_o` = {1'b1, 1'b0, paddr[31:12]}.
  - `refill_done_o`=1.
  - Next state is IDLE.
- Minimum miss-accept to done latency, with the request accepted immediately and beats back-to-back: cycle 0 accept, cycle 1 request handshake, cycles 2–5 beats, cycle 6 TAG/done, cycle 7 IDLE (`miss_ready_o`=1).
- A new miss is accepted no earlier than the cycle after TAG.
- When not writing, `sram_addr_o`, `sram_data_o` and `sram_tag_o` are 0, and `data_we_o`/`tag_we_o` are all-zero.
- `data_we_o` and `tag_we_o` are never high in the same cycle.
- `refill_busy_o`=1 in REQ, RECV and TAG.

Test Plan:
1. Back-to-back refill.
   - Stimulus: miss paddr=0x1C00_0128, way=2'b10, ready immediately, beats 0xA0..0xA3 contiguous with rlast on beat 3.
   - Required: `bus_req_addr_o`=0x1C00_0120.
   - Required: data writes to way1 at `sram_addr_o` 0x048..0x04B.
   - Required: `crit_valid_o` on beat 2 with data 0xA2.
   - Required: `tag_we_o`=2'b10, tag={1,0,0x1C000}, done at cycle 6, `miss_ready_o` at cycle 7.
2. Stalled bus.
   - Stimulus: `bus_req_ready_i` low for 3 cycles, then one idle cycle between each beat.
   - Required: request held stable, writes only on rvalid cycles, cnt unchanged on gaps, done after the 4th beat.
3. Burst-length errors.
   - Stimulus A: rlast on beat 1. Required: `protocol_err_o`=1 and stays 1; refill still completes after 4 beats.
   - Stimulus B: no rlast on beat 3. Required: `protocol_err_o`=1.
4. Reset during RECV after 2 beats.
   - Stimulus: rst_n low for 1 cycle, then stray beats.
   - Required: next cycle IDLE, no `tag_we_o` ever, stray beats produce no writes, `protocol_err_o`=0.
5. Miss while busy and in IDLE.
   - Stimulus: `miss_valid_i` held high during a refill; also `bus_rvalid_i` pulsed while IDLE.
   - Required: `miss_ready_o`=0 until after TAG, second miss accepted in the first IDLE cycle, IDLE beats ignored.
6. Critical word 0 and 3.
   - Stimulus: paddr[3:2]=0, then paddr[3:2]=3.
   - Required: `crit_valid_o` exactly once, on beat 0 and beat 3 respectively; never concurrent with `tag_we_o`.
